// File: rtl/vec_irq_arbiter_pkg.sv
// Shared types and constants for the vectored interrupt arbiter:
// arbiter state encoding, default vector width and standard device vectors.
package irq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int VEC_W_DEF = 9;

  localparam logic [8:0] VEC_LP11    = 9'o200;
  localparam logic [8:0] VEC_DL11_RX = 9'o060;
  localparam logic [8:0] VEC_DL11_TX = 9'o064;

endpackage

// File: rtl/vec_irq_arbiter_prio_enc.sv
// Lowest-index-wins priority encoder: sel is the index of the lowest set
// request bit, any flags that at least one bit is set.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  // scan upward and keep the first hit
  always_comb begin
    sel = {SEL_W{1'b0}};
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        sel = i[SEL_W-1:0];
        any = 1'b1;
      end else begin
        sel = sel;
        any = any;
      end
    end
  end

endmodule

// File: rtl/vec_irq_arbiter.sv
// Shares the CPU irq/iack handshake among N peripherals: fixed-priority grant,
// vector presentation, acknowledge routing and a stuck-acknowledge timeout.
module vec_irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int                 N       = 4,
  parameter int                 VEC_W   = VEC_W_DEF,
  parameter logic [N*VEC_W-1:0] VECTORS = {(N*VEC_W){1'b0}},
  parameter int                 ACK_TMO = 255
) (
  input  logic             clk_p,
  input  logic             sys_init_n,
  input  logic [N-1:0]     dev_irq,
  input  logic [N-1:0]     dev_mask,
  output logic [N-1:0]     dev_iack,
  output logic             cpu_irq,
  input  logic             cpu_iack,
  output logic [VEC_W-1:0] cpu_ivec,
  output logic             tmo_err
);

  localparam int GNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (ACK_TMO > 0) ? $clog2(ACK_TMO + 1) : 1;
  // counter runs 0..ACK_TMO-1 while dev_iack is high, so the grant lasts ACK_TMO cycles
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);

  arb_state_e       state_r;
  logic [GNT_W-1:0] gnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [N-1:0]     pend_s;
  logic [GNT_W-1:0] sel_s;
  logic             any_s;

  assign pend_s = dev_irq & ~dev_mask;

  irq_prio_enc #(
    .N     (N),
    .SEL_W (GNT_W)
  ) u_enc (
    .req (pend_s),
    .sel (sel_s),
    .any (any_s)
  );

  function automatic logic [VEC_W-1:0] vec_of(input logic [GNT_W-1:0] idx);
    vec_of = {VEC_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (idx == i[GNT_W-1:0]) vec_of = VECTORS[i*VEC_W +: VEC_W];
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [GNT_W-1:0] idx);
    onehot      = {N{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

  // arbitration FSM with all CPU- and device-facing outputs registered
  always_ff @(posedge clk_p) begin
    if (!sys_init_n) begin
      state_r  <= IDLE;
      gnt_r    <= {GNT_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      dev_iack <= {N{1'b0}};
      cpu_irq  <= 1'b0;
      cpu_ivec <= {VEC_W{1'b0}};
      tmo_err  <= 1'b0;
    end else begin
      tmo_err <= 1'b0;
      case (state_r)
        IDLE: begin
          // a still-high cpu_iack (e.g. after a timeout) blocks new requests
          if (any_s && !cpu_iack) begin
            gnt_r    <= sel_s;
            cpu_ivec <= vec_of(sel_s);
            cpu_irq  <= 1'b1;
            state_r  <= REQ;
          end else begin
            cpu_irq  <= 1'b0;
            cpu_ivec <= {VEC_W{1'b0}};
          end
        end
        REQ: begin
          if (cpu_iack) begin
            cpu_irq  <= 1'b0;
            dev_iack <= onehot(gnt_r);
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= ACK;
          end else if (!pend_s[gnt_r]) begin
            cpu_irq  <= 1'b0;
            cpu_ivec <= {VEC_W{1'b0}};
            state_r  <= IDLE;
          end else begin
            state_r <= REQ;
          end
        end
        ACK: begin
          if (!cpu_iack) begin
            dev_iack <= {N{1'b0}};
            cpu_ivec <= {VEC_W{1'b0}};
            state_r  <= GAP;
          end else if (cnt_r >= TMO_LAST) begin
            dev_iack <= {N{1'b0}};
            cpu_ivec <= {VEC_W{1'b0}};
            tmo_err  <= 1'b1;
            state_r  <= GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          dev_iack <= {N{1'b0}};
          cpu_irq  <= 1'b0;
          cpu_ivec <= {VEC_W{1'b0}};
        end
      endcase
    end
  end

endmodule
